mult_sequencer: RTL

MULT_SEQUENCER -- requirements
Module: mult_sequencer

---
 rtl/mult_sequencer.sv | 91 +++++++++
 1 files changed

// File: rtl/mult_sequencer.sv
// 4x4 unsigned multiplier built from four passes through a shared external
// 2x2 multiplier, accumulating shifted partial products over four RUN cycles.
module mult_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] op_a,
    input  logic [3:0] op_b,
    output logic [1:0] mul_a,
    output logic [1:0] mul_b,
    input  logic [3:0] mul_p,
    output logic       busy,
    output logic       done,
    output logic [7:0] product
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state_q, state_d;
    logic [1:0] step_q, step_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] product_q, product_d;
    logic [7:0] term;

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        product_d = product_q;
        mul_a     = 2'b00;
        mul_b     = 2'b00;
        term      = 8'h00;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    acc_d   = 8'h00;
                    step_d  = 2'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // step[0] picks the half of A, step[1] the half of B
                mul_a = step_q[0] ? a_q[3:2] : a_q[1:0];
                mul_b = step_q[1] ? b_q[3:2] : b_q[1:0];
                unique case (step_q)
                    2'd0:    term = {4'b0000, mul_p};
                    2'd1,
                    2'd2:    term = {2'b00, mul_p, 2'b00};
                    default: term = {mul_p, 4'b0000};
                endcase
                acc_d  = acc_q + term;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    product_d = acc_q + term;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            step_q    <= 2'd0;
            a_q       <= 4'h0;
            b_q       <= 4'h0;
            acc_q     <= 8'h00;
            product_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule
